// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared defaults and pointer helpers for the FIFO controller
// Contents:
//   FIFO_DEPTH / FIFO_AW : default entry count and address width
//   fifo_count_t         : occupancy type for the default geometry (AW+1 bits)
//   ptr_wrap()           : next pointer value with explicit DEPTH-1 -> 0 wrap
package fifo_pkg;

    localparam int unsigned FIFO_DEPTH = 8;
    localparam int unsigned FIFO_AW    = 3;

    typedef logic [FIFO_AW:0] fifo_count_t;

    // Compare-based wrap so non-power-of-2 depths never address past DEPTH-1.
    function automatic int unsigned ptr_wrap(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/fifo_occ_counter.sv
// rtl/fifo_occ_counter.sv - saturating up/down occupancy counter
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   inc_i, dec_i  : count up / count down (both or neither hold)
//   count_o       : registered occupancy, 0..DEPTH
//   count_next_o  : value count_o takes at the next edge (lets flags register in step)
module fifo_occ_counter
    import fifo_pkg::*;
#(
    parameter int unsigned DEPTH = FIFO_DEPTH,
    parameter int unsigned AW    = FIFO_AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc_i,
    input  logic          dec_i,
    output logic [AW:0]   count_o,
    output logic [AW:0]   count_next_o
);

    localparam logic [AW:0] COUNT_MAX = (AW+1)'(DEPTH);

    logic [AW:0] count_q;
    logic [AW:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && !dec_i && (count_q != COUNT_MAX)) begin
            count_d = count_q + 1'b1;
        end else if (dec_i && !inc_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o      = count_q;
    assign count_next_o = reset ? '0 : count_d;

endmodule

// File: rtl/fifo_ctrl.sv
// rtl/fifo_ctrl.sv - pointer/flag controller sequencing an external dual-port RAM
// Optional feature macro: FIFO_CTRL_ALMOST_FLAGS_EN (registered almost_full/almost_empty;
// when undefined both outputs are tied low).
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   wr_req, rd_req        : producer push / consumer pop requests
//   err_clr               : clears sticky overflow/underflow
//   wr_en, rd_en          : RAM write/read strobes (accepted push/pop)
//   wr_addr, rd_addr      : RAM write/read pointers
//   count                 : occupancy 0..DEPTH
//   full, empty           : registered count==DEPTH / count==0
//   almost_full/empty     : registered count >= DEPTH-AF_MARGIN / count <= AE_MARGIN
//   overflow, underflow   : sticky refused-push / refused-pop flags
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned DEPTH     = FIFO_DEPTH,
    parameter int unsigned AW        = FIFO_AW,
    parameter int unsigned AF_MARGIN = 1,
    parameter int unsigned AE_MARGIN = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_req,
    input  logic          rd_req,
    input  logic          err_clr,
    output logic          wr_en,
    output logic          rd_en,
    output logic [AW-1:0] wr_addr,
    output logic [AW-1:0] rd_addr,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic          almost_empty,
    output logic          overflow,
    output logic          underflow
);

    if (DEPTH < 2 || AW != $clog2(DEPTH) || AF_MARGIN >= DEPTH || AE_MARGIN >= DEPTH) begin : g_bad_params
        $error("fifo_ctrl: inconsistent DEPTH/AW/margin parameters");
    end

    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic          full_q, empty_q;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic [AW:0]   count_next;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside it.
    assign rd_en = rd_req & ~empty_q;
    assign wr_en = wr_req & (~full_q | rd_en);

    fifo_occ_counter #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_occ (
        .clk          (clk),
        .reset        (reset),
        .inc_i        (wr_en),
        .dec_i        (rd_en),
        .count_o      (count),
        .count_next_o (count_next)
    );

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        if (wr_en) wr_ptr_d = AW'(ptr_wrap(32'(wr_ptr_q), DEPTH));
        if (rd_en) rd_ptr_d = AW'(ptr_wrap(32'(rd_ptr_q), DEPTH));
        // Set has priority over err_clr so an error in the clearing cycle is not lost.
        overflow_d  = (wr_req & ~wr_en) | (overflow_q  & ~err_clr);
        underflow_d = (rd_req & ~rd_en) | (underflow_q & ~err_clr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            full_q      <= (count_next == FULL_LEVEL);
            empty_q     <= (count_next == '0);
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

`ifdef FIFO_CTRL_ALMOST_FLAGS_EN
    localparam logic [AW:0] AF_LEVEL = (AW+1)'(DEPTH - AF_MARGIN);
    localparam logic [AW:0] AE_LEVEL = (AW+1)'(AE_MARGIN);

    logic almost_full_q, almost_empty_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
        end else begin
            almost_full_q  <= (count_next >= AF_LEVEL);
            almost_empty_q <= (count_next <= AE_LEVEL);
        end
    end

    assign almost_full  = almost_full_q;
    assign almost_empty = almost_empty_q;
`else
    assign almost_full  = 1'b0;
    assign almost_empty = 1'b0;
`endif

    assign wr_addr   = wr_ptr_q;
    assign rd_addr   = rd_ptr_q;
    assign full      = full_q;
    assign empty     = empty_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb/tb_fifo_ctrl.sv - scoreboard bench for fifo_ctrl against an occupancy reference model
module tb_fifo_ctrl;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          wr_req = 1'b0, rd_req = 1'b0, err_clr = 1'b0;
    logic          wr_en, rd_en;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [AW:0]   count;
    logic          full, empty, almost_full, almost_empty, overflow, underflow;

    fifo_ctrl #(.DEPTH(DEPTH), .AW(AW), .AF_MARGIN(1), .AE_MARGIN(1)) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_req       (wr_req),
        .rd_req       (rd_req),
        .err_clr      (err_clr),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .wr_addr      (wr_addr),
        .rd_addr      (rd_addr),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int  wr_en, rd_en, wa, ra, cnt, full, empty, af, ae, ovf, udf;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference state: plain integers and modular arithmetic.
    int  m_cnt = 0, m_wp = 0, m_rp = 0;
    bit  m_ovf = 0, m_udf = 0, m_valid = 0;

    task automatic chk(input string name, input logic [31:0] act, input int expv);
        n_cmp++;
        if (act !== 32'(expv)) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    task automatic cycle(input bit w, input bit r, input bit c, input bit rs);
        exp_t e;
        bit   acc_rd, acc_wr;
        wr_req  = w;
        rd_req  = r;
        err_clr = c;
        reset   = rs;
        acc_rd  = r && (m_cnt > 0);
        acc_wr  = w && ((m_cnt < DEPTH) || acc_rd);
        if (m_valid) begin
            e.wr_en = acc_wr;
            e.rd_en = acc_rd;
            e.wa    = m_wp;
            e.ra    = m_rp;
            e.cnt   = m_cnt;
            e.full  = (m_cnt == DEPTH);
            e.empty = (m_cnt == 0);
`ifdef FIFO_CTRL_ALMOST_FLAGS_EN
            e.af    = (m_cnt >= DEPTH - 1);
            e.ae    = (m_cnt <= 1);
`else
            e.af    = 0;
            e.ae    = 0;
`endif
            e.ovf   = m_ovf;
            e.udf   = m_udf;
            exp_q.push_back(e);
        end
        if (rs) begin
            m_cnt = 0; m_wp = 0; m_rp = 0; m_ovf = 0; m_udf = 0; m_valid = 1;
        end else begin
            m_cnt = m_cnt + int'(acc_wr) - int'(acc_rd);
            if (acc_wr) m_wp = (m_wp + 1) % DEPTH;
            if (acc_rd) m_rp = (m_rp + 1) % DEPTH;
            m_ovf = (w && !acc_wr) || (m_ovf && !c);
            m_udf = (r && !acc_rd) || (m_udf && !c);
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: checks the DUT against the oldest pending expectation each cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("wr_en",        32'(wr_en),        e.wr_en);
            chk("rd_en",        32'(rd_en),        e.rd_en);
            chk("wr_addr",      32'(wr_addr),      e.wa);
            chk("rd_addr",      32'(rd_addr),      e.ra);
            chk("count",        32'(count),        e.cnt);
            chk("full",         32'(full),         e.full);
            chk("empty",        32'(empty),        e.empty);
            chk("almost_full",  32'(almost_full),  e.af);
            chk("almost_empty", 32'(almost_empty), e.ae);
            chk("overflow",     32'(overflow),     e.ovf);
            chk("underflow",    32'(underflow),    e.udf);
        end
    end

    initial begin
        @(posedge clk);
        #1;
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        for (int i = 0; i < 9; i++) cycle(1, 0, 0, 0);   // fill, ninth push refused
        cycle(1, 1, 0, 0);                                // full: push+pop both accepted
        cycle(1, 1, 0, 0);
        cycle(0, 0, 1, 0);
        for (int i = 0; i < 8; i++) cycle(0, 1, 0, 0);   // drain
        cycle(0, 1, 0, 0);                                // pop on empty refused
        cycle(0, 0, 1, 0);
        cycle(0, 0, 0, 0);
        cycle(1, 1, 0, 0);                                // empty: only push accepted
        cycle(0, 1, 0, 0);
        cycle(0, 1, 1, 0);                                // set wins over clear
        cycle(0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 1);                                // reset mid-operation
        cycle(0, 0, 0, 0);
        for (int i = 0; i < 7; i++) cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);

        for (int i = 0; i < 600; i++) begin
            int pw, pr;
            pw = (i < 200) ? 70 : (i < 400) ? 30 : 50;
            pr = (i < 200) ? 30 : (i < 400) ? 70 : 50;
            cycle($urandom_range(0, 99) < pw,
                  $urandom_range(0, 99) < pr,
                  $urandom_range(0, 15) == 0,
                  $urandom_range(0, 79) == 0);
        end
        cycle(0, 0, 0, 0);

        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
